// File: rtl/pipe_ir_ctrl_pkg.sv
// Shared pipeline definitions: instruction field constants, the bubble encoding and the
// stage record carried through D/E/M/W. The hazard unit uses the same constants.
package pipe_ir_ctrl_pkg;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam int          WD_LIMIT_DEF = 3;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;
    localparam int FN_HI = 5;
    localparam int FN_LO = 0;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_ORI   = 6'h0D,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_JR   = 6'h08,
        FN_ADDU = 6'h21,
        FN_SUBU = 6'h23
    } funct_e;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        v;
    } stage_t;

    // All-zero word decodes as sll $0,$0,0, so a bubble never writes a register.
    localparam stage_t BUBBLE = '{ir: NOP, pc: 32'h0, v: 1'b0};

endpackage

// File: rtl/pipe_ir_ctrl_if.sv
// Fetch-side inputs and per-stage instruction/PC outputs of the IR controller.
interface pipe_ir_ctrl_if;

    logic        stall;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic        pc_en;
    logic [31:0] ir_d, ir_e, ir_m, ir_w;
    logic [31:0] pc_d, pc_e, pc_m, pc_w;
    logic        v_d, v_e, v_m, v_w;
    logic [31:0] stall_cnt;
    logic [31:0] retire_cnt;
    logic        stall_err;

    modport master (
        output stall, instr_f, pc_f,
        input  pc_en, ir_d, ir_e, ir_m, ir_w, pc_d, pc_e, pc_m, pc_w,
        input  v_d, v_e, v_m, v_w, stall_cnt, retire_cnt, stall_err
    );

    modport slave (
        input  stall, instr_f, pc_f,
        output pc_en, ir_d, ir_e, ir_m, ir_w, pc_d, pc_e, pc_m, pc_w,
        output v_d, v_e, v_m, v_w, stall_cnt, retire_cnt, stall_err
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register holding (ir, pc, v); clear beats enable.
module pipe_stage_reg
    import pipe_ir_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   en_i,
    input  logic   clr_i,
    input  stage_t d_i,
    output stage_t q_o
);

    stage_t stage_q, stage_d;

    always_comb begin
        stage_d = stage_q;
        if (clr_i) begin
            stage_d = BUBBLE;
        end else if (en_i) begin
            stage_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        stage_q <= stage_d;
    end

    assign q_o = stage_q;

endmodule

// File: rtl/pipe_ir_ctrl.sv
// D/E/M/W instruction and PC registers with stall handling (freeze D, bubble E, drain M/W),
// saturating stall/retire counters and a sticky stuck-stall watchdog.
module pipe_ir_ctrl
    import pipe_ir_ctrl_pkg::*;
#(
    parameter int WD_LIMIT = WD_LIMIT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    pipe_ir_ctrl_if.slave  bus
);

    localparam int             RUN_W   = $clog2(WD_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(WD_LIMIT);

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    stage_t fetch_s, d_s, e_s, m_s, w_s;

    assign fetch_s = '{ir: bus.instr_f, pc: bus.pc_f, v: 1'b1};

    pipe_stage_reg u_d (.clk(clk), .en_i(~bus.stall), .clr_i(reset),
                        .d_i(fetch_s), .q_o(d_s));
    pipe_stage_reg u_e (.clk(clk), .en_i(1'b1), .clr_i(reset | bus.stall),
                        .d_i(d_s), .q_o(e_s));
    pipe_stage_reg u_m (.clk(clk), .en_i(1'b1), .clr_i(reset),
                        .d_i(e_s), .q_o(m_s));
    pipe_stage_reg u_w (.clk(clk), .en_i(1'b1), .clr_i(reset),
                        .d_i(m_s), .q_o(w_s));

    logic [31:0]      stall_cnt_q, stall_cnt_d;
    logic [31:0]      retire_cnt_q, retire_cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             stall_err_q, stall_err_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        retire_cnt_d = retire_cnt_q;
        run_d        = run_q;
        stall_err_d  = stall_err_q;
        if (reset) begin
            stall_cnt_d  = '0;
            retire_cnt_d = '0;
            run_d        = '0;
            stall_err_d  = 1'b0;
        end else begin
            if (bus.stall) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
                run_d       = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
            end else begin
                run_d = '0;
            end
            if (w_s.v) begin
                retire_cnt_d = sat_inc(retire_cnt_q);
            end
            // Diagnostic only: sticky until reset, never feeds back into the pipeline.
            if (run_d == RUN_MAX) begin
                stall_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        stall_cnt_q  <= stall_cnt_d;
        retire_cnt_q <= retire_cnt_d;
        run_q        <= run_d;
        stall_err_q  <= stall_err_d;
    end

    assign bus.pc_en      = ~bus.stall & ~reset;
    assign bus.ir_d       = d_s.ir;
    assign bus.ir_e       = e_s.ir;
    assign bus.ir_m       = m_s.ir;
    assign bus.ir_w       = w_s.ir;
    assign bus.pc_d       = d_s.pc;
    assign bus.pc_e       = e_s.pc;
    assign bus.pc_m       = m_s.pc;
    assign bus.pc_w       = w_s.pc;
    assign bus.v_d        = d_s.v;
    assign bus.v_e        = e_s.v;
    assign bus.v_m        = m_s.v;
    assign bus.v_w        = w_s.v;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.retire_cnt = retire_cnt_q;
    assign bus.stall_err  = stall_err_q;

endmodule
